// File: rtl/spy_event_reader.sv
// Locates the N-th most recent event in a frozen spy buffer by walking the
// event list backwards, then streams that event's words on a valid/ready port.
module spy_event_reader #(
  parameter int DATAWIDTH = 64,
  parameter int MEMWIDTH  = 6,
  parameter int METAWIDTH = 4
) (
  input  logic                 clock,
  input  logic                 resetbar,
  input  logic                 start,
  input  logic [METAWIDTH-1:0] event_index,
  input  logic                 abort,
  input  logic [MEMWIDTH-1:0]  mem_wptr,
  input  logic [METAWIDTH-1:0] meta_write_addr,
  output logic                 meta_read_enable,
  output logic [METAWIDTH-1:0] meta_read_addr,
  input  logic [MEMWIDTH:0]    meta_read_data,
  output logic                 read_enable,
  output logic [MEMWIDTH-1:0]  read_addr,
  input  logic [DATAWIDTH:0]   data_in,
  output logic [DATAWIDTH:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 not_found,
  output logic [MEMWIDTH:0]    event_length,
  output logic [2:0]           debug_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_MREAD  = 3'd1;
  localparam logic [2:0] S_MEVAL  = 3'd2;
  localparam logic [2:0] S_DREAD  = 3'd3;
  localparam logic [2:0] S_DOUT   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]           state;
  logic [METAWIDTH-1:0] ptr;
  logic [METAWIDTH-1:0] skip;
  logic [METAWIDTH-1:0] scanned;
  logic [MEMWIDTH-1:0]  end_ptr;
  logic [MEMWIDTH-1:0]  raddr;
  logic [MEMWIDTH:0]    remaining;
  logic [DATAWIDTH:0]   hold_data;
  logic                 first_beat;
  logic                 not_found_q;
  logic [MEMWIDTH:0]    event_length_q;

  logic                 meta_sentinel;
  logic [MEMWIDTH-1:0]  meta_ptr;
  logic [MEMWIDTH-1:0]  diff;
  logic [MEMWIDTH:0]    located_len;
  logic [METAWIDTH-1:0] scanned_next;
  logic                 last_word;

  assign meta_sentinel = meta_read_data[MEMWIDTH];
  assign meta_ptr      = meta_read_data[MEMWIDTH-1:0];
  assign diff          = end_ptr - meta_ptr;
  // A zero distance means the event fills the whole spy memory.
  assign located_len   = {(diff == '0), diff};
  assign scanned_next  = scanned + 1'b1;
  assign last_word     = (remaining == (MEMWIDTH+1)'(1));

  // Stream handshake: a word transfers on any edge where out_valid && out_ready;
  // out_valid never drops and out_data never changes until that transfer.
  assign meta_read_enable = (state == S_MREAD);
  assign meta_read_addr   = (state == S_MREAD) ? ptr : '0;
  assign read_enable      = (state == S_DREAD);
  assign read_addr        = (state == S_DREAD) ? raddr : '0;
  assign out_valid        = (state == S_DOUT);
  assign out_last         = (state == S_DOUT) && last_word;
  assign out_data         = (state != S_DOUT) ? '0 : (first_beat ? data_in : hold_data);
  assign busy             = (state != S_IDLE);
  assign done             = (state == S_FINISH);
  assign not_found        = not_found_q;
  assign event_length     = event_length_q;
  assign debug_state      = state;

  always_ff @(posedge clock or negedge resetbar) begin
    if (!resetbar) begin
      state          <= S_IDLE;
      ptr            <= '0;
      skip           <= '0;
      scanned        <= '0;
      end_ptr        <= '0;
      raddr          <= '0;
      remaining      <= '0;
      hold_data      <= '0;
      first_beat     <= 1'b0;
      not_found_q    <= 1'b0;
      event_length_q <= '0;
    end else if (abort) begin
      state      <= S_IDLE;
      first_beat <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ptr         <= meta_write_addr - 1'b1;
            end_ptr     <= mem_wptr;
            skip        <= event_index;
            scanned     <= '0;
            not_found_q <= 1'b0;
            state       <= S_MREAD;
          end
        end
        S_MREAD: state <= S_MEVAL;
        S_MEVAL: begin
          scanned <= scanned_next;
          if (!meta_sentinel && skip == '0) begin
            raddr          <= meta_ptr;
            remaining      <= located_len;
            event_length_q <= located_len;
            state          <= S_DREAD;
          end else begin
            ptr <= ptr - 1'b1;
            if (!meta_sentinel) begin
              end_ptr <= meta_ptr;
              skip    <= skip - 1'b1;
            end
            if (scanned_next == '1) begin
              not_found_q <= 1'b1;
              state       <= S_FINISH;
            end else begin
              state <= S_MREAD;
            end
          end
        end
        S_DREAD: begin
          first_beat <= 1'b1;
          state      <= S_DOUT;
        end
        S_DOUT: begin
          // Memory data is only guaranteed on the first cycle; keep a copy for stalls.
          first_beat <= 1'b0;
          if (first_beat) hold_data <= data_in;
          if (out_ready) begin
            raddr     <= raddr + 1'b1;
            remaining <= remaining - 1'b1;
            state     <= last_word ? S_FINISH : S_DREAD;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
